execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/y86_pkg.sv | 57 +++++
 rtl/execute_stage_if.sv | 32 +++
 rtl/y86_alu.sv | 40 ++++
 rtl/execute_stage.sv | 156 +++++++++++++++
 tb/tb_execute_stage.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, ALU/condition functions, status codes
// and the bubble contents loaded into the M register.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_fn_e;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] B_STAT  = S_AOK;
    localparam logic [3:0] B_ICODE = I_NOP;
    localparam logic [3:0] B_IFUN  = 4'h0;
    localparam logic [3:0] B_REG   = RNONE;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RST = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    function automatic logic stat_blocks(input logic [2:0] s);
        return (s == S_ADR) || (s == S_HLT) || (s == S_INS);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// E-register inputs and M-register outputs of the execute stage,
// bundled for benches and neighbouring stages.
interface execute_stage_if #(
    parameter int WORD = 64
);
    logic [2:0]      E_stat;
    logic [3:0]      E_icode, E_ifun, E_rA, E_rB, E_dstE, E_dstM;
    logic [WORD-1:0] E_valA, E_valB, E_valC, E_valP;
    logic [2:0]      m_stat, W_stat;
    logic            M_bubble;
    logic [WORD-1:0] e_valE;
    logic [3:0]      e_dstE;
    logic            e_cnd;
    logic [2:0]      M_stat;
    logic [3:0]      M_icode, M_ifun, M_rA, M_rB, M_dstE, M_dstM;
    logic [WORD-1:0] M_valA, M_valB, M_valC, M_valP, M_valE;
    logic            M_cnd;

    modport master (
        output E_stat, E_icode, E_ifun, E_rA, E_rB, E_dstE, E_dstM,
        output E_valA, E_valB, E_valC, E_valP, m_stat, W_stat, M_bubble,
        input  e_valE, e_dstE, e_cnd, M_stat, M_icode, M_ifun, M_rA, M_rB,
        input  M_dstE, M_dstM, M_valA, M_valB, M_valC, M_valP, M_valE, M_cnd
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_rA, E_rB, E_dstE, E_dstM,
        input  E_valA, E_valB, E_valC, E_valP, m_stat, W_stat, M_bubble,
        output e_valE, e_dstE, e_cnd, M_stat, M_icode, M_ifun, M_rA, M_rB,
        output M_dstE, M_dstM, M_valA, M_valB, M_valC, M_valP, M_valE, M_cnd
    );
endinterface

// File: rtl/y86_alu.sv
// Combinational ALU: result = b op a, plus zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
#(
    parameter int WORD = 64
) (
    input  logic [WORD-1:0] a_i,
    input  logic [WORD-1:0] b_i,
    input  alu_fn_e         fn_i,
    output logic [WORD-1:0] res_o,
    output cc_t             flags_o
);
    logic sa, sb, sr;

    always_comb begin
        res_o = '0;
        unique case (fn_i)
            ALU_ADD: res_o = b_i + a_i;
            ALU_SUB: res_o = b_i - a_i;
            ALU_AND: res_o = b_i & a_i;
            ALU_XOR: res_o = b_i ^ a_i;
            default: res_o = '0;
        endcase
    end

    assign sa = a_i[WORD-1];
    assign sb = b_i[WORD-1];
    assign sr = res_o[WORD-1];

    always_comb begin
        flags_o.zf = (res_o == '0);
        flags_o.sf = sr;
        flags_o.of = 1'b0;
        unique case (fn_i)
            ALU_ADD: flags_o.of = (sa == sb) && (sr != sa);
            ALU_SUB: flags_o.of = (sa != sb) && (sr != sb);
            default: flags_o.of = 1'b0;
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition
// and the E->M pipeline register.
module execute_stage
    import y86_pkg::*;
#(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [3:0]      E_rA,
    input  logic [3:0]      E_rB,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic [WORD-1:0] E_valA,
    input  logic [WORD-1:0] E_valB,
    input  logic [WORD-1:0] E_valC,
    input  logic [WORD-1:0] E_valP,
    input  logic [2:0]      m_stat,
    input  logic [2:0]      W_stat,
    input  logic            M_bubble,
    output logic [WORD-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic            e_cnd,
    output logic [2:0]      M_stat,
    output logic [3:0]      M_icode,
    output logic [3:0]      M_ifun,
    output logic [3:0]      M_rA,
    output logic [3:0]      M_rB,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM,
    output logic [WORD-1:0] M_valA,
    output logic [WORD-1:0] M_valB,
    output logic [WORD-1:0] M_valC,
    output logic [WORD-1:0] M_valP,
    output logic [WORD-1:0] M_valE,
    output logic            M_cnd
);
    typedef struct packed {
        logic [2:0]      stat;
        logic [3:0]      icode, ifun, rA, rB, dstE, dstM;
        logic [WORD-1:0] valA, valB, valC, valP, valE;
        logic            cnd;
    } mreg_t;

    localparam mreg_t M_BUB = '{
        stat: B_STAT, icode: B_ICODE, ifun: B_IFUN,
        rA: B_REG, rB: B_REG, dstE: B_REG, dstM: B_REG,
        default: '0
    };

    mreg_t           m_q, m_d;
    cc_t             cc_q, cc_d, alu_cc;
    logic [WORD-1:0] alu_a, alu_b;
    alu_fn_e         alu_fn;
    logic            set_cc;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fn = ALU_ADD;
        unique case (1'b1)
            (E_icode == I_OPQ): begin
                alu_a  = E_valA;
                alu_b  = E_valB;
                alu_fn = alu_fn_e'(E_ifun[1:0]);
            end
            (E_icode == I_CMOVXX): alu_a = E_valA;
            (E_icode == I_IRMOVQ): alu_a = E_valC;
            (E_icode == I_RMMOVQ),
            (E_icode == I_MRMOVQ): begin
                alu_a = E_valC;
                alu_b = E_valB;
            end
            (E_icode == I_CALL),
            (E_icode == I_PUSHQ): begin
                alu_a  = WORD'(8);
                alu_b  = E_valB;
                alu_fn = ALU_SUB;
            end
            (E_icode == I_RET),
            (E_icode == I_POPQ): begin
                alu_a = WORD'(8);
                alu_b = E_valB;
            end
            default: ;
        endcase
    end

    y86_alu #(.WORD(WORD)) u_alu (
        .a_i     (alu_a),
        .b_i     (alu_b),
        .fn_i    (alu_fn),
        .res_o   (e_valE),
        .flags_o (alu_cc)
    );

    // Condition always sees the CC as it was before this cycle's update.
    always_comb begin
        e_cnd = 1'b0;
        unique case (E_ifun)
            C_YES:   e_cnd = 1'b1;
            C_LE:    e_cnd = (cc_q.sf ^ cc_q.of) | cc_q.zf;
            C_L:     e_cnd = cc_q.sf ^ cc_q.of;
            C_E:     e_cnd = cc_q.zf;
            C_NE:    e_cnd = ~cc_q.zf;
            C_GE:    e_cnd = ~(cc_q.sf ^ cc_q.of);
            C_G:     e_cnd = ~(cc_q.sf ^ cc_q.of) & ~cc_q.zf;
            default: e_cnd = 1'b0;
        endcase
    end

    assign e_dstE = (E_icode == I_CMOVXX && !e_cnd) ? RNONE : E_dstE;

    assign set_cc = (E_icode == I_OPQ) && !M_bubble && (E_stat == S_AOK)
                  && !stat_blocks(m_stat) && !stat_blocks(W_stat);

    always_comb begin
        cc_d = set_cc ? alu_cc : cc_q;
        m_d  = M_BUB;
        if (!M_bubble) begin
            m_d = '{
                stat: E_stat, icode: E_icode, ifun: E_ifun,
                rA: E_rA, rB: E_rB, dstE: e_dstE, dstM: E_dstM,
                valA: E_valA, valB: E_valB, valC: E_valC,
                valP: E_valP, valE: e_valE, cnd: e_cnd
            };
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q  <= M_BUB;
            cc_q <= CC_RST;
        end else begin
            m_q  <= m_d;
            cc_q <= cc_d;
        end
    end

    assign M_stat  = m_q.stat;
    assign M_icode = m_q.icode;
    assign M_ifun  = m_q.ifun;
    assign M_rA    = m_q.rA;
    assign M_rB    = m_q.rB;
    assign M_dstE  = m_q.dstE;
    assign M_dstM  = m_q.dstM;
    assign M_valA  = m_q.valA;
    assign M_valB  = m_q.valB;
    assign M_valC  = m_q.valC;
    assign M_valP  = m_q.valP;
    assign M_valE  = m_q.valE;
    assign M_cnd   = m_q.cnd;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios then random instructions
// checked against a spec-level model of the ALU, CC and M register.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    execute_stage_if #(.WORD(64)) vif ();

    execute_stage #(.WORD(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E_stat   (vif.E_stat),
        .E_icode  (vif.E_icode),
        .E_ifun   (vif.E_ifun),
        .E_rA     (vif.E_rA),
        .E_rB     (vif.E_rB),
        .E_dstE   (vif.E_dstE),
        .E_dstM   (vif.E_dstM),
        .E_valA   (vif.E_valA),
        .E_valB   (vif.E_valB),
        .E_valC   (vif.E_valC),
        .E_valP   (vif.E_valP),
        .m_stat   (vif.m_stat),
        .W_stat   (vif.W_stat),
        .M_bubble (vif.M_bubble),
        .e_valE   (vif.e_valE),
        .e_dstE   (vif.e_dstE),
        .e_cnd    (vif.e_cnd),
        .M_stat   (vif.M_stat),
        .M_icode  (vif.M_icode),
        .M_ifun   (vif.M_ifun),
        .M_rA     (vif.M_rA),
        .M_rB     (vif.M_rB),
        .M_dstE   (vif.M_dstE),
        .M_dstM   (vif.M_dstM),
        .M_valA   (vif.M_valA),
        .M_valB   (vif.M_valB),
        .M_valC   (vif.M_valC),
        .M_valP   (vif.M_valP),
        .M_valE   (vif.M_valE),
        .M_cnd    (vif.M_cnd)
    );

    always #5 clk = ~clk;

    // Model condition codes.
    logic zf, sf, of;

    // Last combinational outputs seen by step().
    logic [63:0] last_vale;
    logic [3:0]  last_dste;
    logic        last_cnd;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdl_vale(input logic [3:0] ic,
        input logic [3:0] fn, input logic [63:0] a, b, c);
        case (ic)
            4'h6: case (fn)
                4'h0: return b + a;
                4'h1: return b - a;
                4'h2: return b & a;
                4'h3: return b ^ a;
                default: return 64'd0;
            endcase
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    // Overflow judged from a 65-bit sign-extended result.
    function automatic logic [2:0] mdl_flags(input logic [3:0] fn,
        input logic [63:0] a, b);
        logic [64:0] w;
        logic [63:0] r;
        logic        o;
        r = mdl_vale(4'h6, fn, a, b, 64'd0);
        o = 1'b0;
        if (fn == 4'h0) begin
            w = {b[63], b} + {a[63], a};
            o = (w[64] != w[63]);
        end else if (fn == 4'h1) begin
            w = {b[63], b} - {a[63], a};
            o = (w[64] != w[63]);
        end
        return {(r == 64'd0), r[63], o};
    endfunction

    function automatic logic mdl_cond(input logic [3:0] fn);
        case (fn)
            4'h0: return 1'b1;
            4'h1: return (sf != of) || zf;
            4'h2: return (sf != of);
            4'h3: return zf;
            4'h4: return !zf;
            4'h5: return (sf == of);
            4'h6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic blk(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    task automatic chk_m(input string tag, input logic [2:0] st,
        input logic [3:0] ic, fn, ra, rb, de, dm,
        input logic [63:0] a, b, c, p, ve, input logic cn);
        chk({tag, ".M_stat"}, 64'(vif.M_stat), 64'(st));
        chk({tag, ".M_icode"}, 64'(vif.M_icode), 64'(ic));
        chk({tag, ".M_ifun"}, 64'(vif.M_ifun), 64'(fn));
        chk({tag, ".M_rA"}, 64'(vif.M_rA), 64'(ra));
        chk({tag, ".M_rB"}, 64'(vif.M_rB), 64'(rb));
        chk({tag, ".M_dstE"}, 64'(vif.M_dstE), 64'(de));
        chk({tag, ".M_dstM"}, 64'(vif.M_dstM), 64'(dm));
        chk({tag, ".M_valA"}, vif.M_valA, a);
        chk({tag, ".M_valB"}, vif.M_valB, b);
        chk({tag, ".M_valC"}, vif.M_valC, c);
        chk({tag, ".M_valP"}, vif.M_valP, p);
        chk({tag, ".M_valE"}, vif.M_valE, ve);
        chk({tag, ".M_cnd"}, 64'(vif.M_cnd), 64'(cn));
    endtask

    // Drive one E instruction, check e_* mid-cycle, then M after the edge.
    task automatic step(input string tag, input logic [3:0] ic, fn,
        input logic [63:0] a, b, c, input logic [3:0] de,
        input logic [2:0] es, ms, ws, input logic bub, rn);
        logic [3:0]  ra, rb, dm;
        logic [63:0] p, ve;
        logic        cn;
        logic [3:0]  xde;
        logic [2:0]  fl;
        ra = 4'($urandom);
        rb = 4'($urandom);
        dm = 4'($urandom);
        p  = {$urandom, $urandom};
        vif.E_icode = ic;   vif.E_ifun = fn;
        vif.E_valA = a;     vif.E_valB = b;
        vif.E_valC = c;     vif.E_valP = p;
        vif.E_rA = ra;      vif.E_rB = rb;
        vif.E_dstE = de;    vif.E_dstM = dm;
        vif.E_stat = es;    vif.m_stat = ms;
        vif.W_stat = ws;    vif.M_bubble = bub;
        rst_n = rn;
        #4;
        ve  = mdl_vale(ic, fn, a, b, c);
        cn  = mdl_cond(fn);
        xde = (ic == 4'h2 && !cn) ? 4'hF : de;
        last_vale = vif.e_valE;
        last_dste = vif.e_dstE;
        last_cnd  = vif.e_cnd;
        chk({tag, ".e_valE"}, vif.e_valE, ve);
        chk({tag, ".e_cnd"}, 64'(vif.e_cnd), 64'(cn));
        chk({tag, ".e_dstE"}, 64'(vif.e_dstE), 64'(xde));
        @(posedge clk);
        #1;
        if (!rn) begin
            {zf, sf, of} = 3'b100;
        end else if (!bub && ic == 4'h6 && es == 3'd1
                     && !blk(ms) && !blk(ws)) begin
            fl = mdl_flags(fn, a, b);
            {zf, sf, of} = fl;
        end
        if (!rn || bub)
            chk_m(tag, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
                  64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        else
            chk_m(tag, es, ic, fn, ra, rb, xde, dm, a, b, c, p, ve, cn);
    endtask

    task automatic jxx(input string tag, input logic [3:0] fn);
        step(tag, 4'h7, fn, 64'd0, 64'd0, 64'd0, 4'hF,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
    endtask

    initial begin
        vif.E_icode = 4'h1; vif.E_ifun = 4'h0;
        vif.E_valA = '0; vif.E_valB = '0; vif.E_valC = '0; vif.E_valP = '0;
        vif.E_rA = 4'hF; vif.E_rB = 4'hF; vif.E_dstE = 4'hF; vif.E_dstM = 4'hF;
        vif.E_stat = 3'd1; vif.m_stat = 3'd1; vif.W_stat = 3'd1;
        vif.M_bubble = 1'b0;
        rst_n = 1'b0;
        {zf, sf, of} = 3'b100;
        repeat (2) @(posedge clk);
        #1;
        chk_m("reset", 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
              64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
        jxx("reset_cc_e", 4'h3);
        chk("reset_zf", 64'(last_cnd), 64'd1);

        // sub 3-5: negative, no overflow
        step("sub", 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 4'h2,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        chk("sub_valE", last_vale, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_MvalE", vif.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        jxx("sub_cc_e", 4'h3);
        chk("sub_zf0", 64'(last_cnd), 64'd0);
        jxx("sub_cc_l", 4'h2);
        chk("sub_sf1of0", 64'(last_cnd), 64'd1);

        step("addov", 4'h6, 4'h0, 64'h4000_0000_0000_0000,
             64'h4000_0000_0000_0000, 64'd0, 4'h3,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        chk("addov_valE", last_vale, 64'h8000_0000_0000_0000);
        jxx("addov_cc_l", 4'h2);
        chk("addov_sf1of1", 64'(last_cnd), 64'd0);
        jxx("addov_cc_ne", 4'h4);
        chk("addov_zf0", 64'(last_cnd), 64'd1);

        step("xorz", 4'h6, 4'h3, 64'h1234, 64'h1234, 64'd0, 4'h3,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        step("cmovne", 4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'h3,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        chk("cmovne_cnd", 64'(last_cnd), 64'd0);
        chk("cmovne_dstE", 64'(last_dste), 64'hF);
        chk("cmovne_MdstE", 64'(vif.M_dstE), 64'hF);

        // CC now ZF=0: blocked ops must leave it alone
        step("sub_nz", 4'h6, 4'h1, 64'd1, 64'd9, 64'd0, 4'h1,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        step("xor_adr", 4'h6, 4'h3, 64'h77, 64'h77, 64'd0, 4'h1,
             3'd1, 3'd3, 3'd1, 1'b0, 1'b1);
        jxx("adr_cc_e", 4'h3);
        chk("adr_hold", 64'(last_cnd), 64'd0);
        step("xor_bub", 4'h6, 4'h3, 64'h77, 64'h77, 64'd0, 4'h1,
             3'd1, 3'd1, 3'd1, 1'b1, 1'b1);
        chk("bub_icode", 64'(vif.M_icode), 64'h1);
        chk("bub_stat", 64'(vif.M_stat), 64'h1);
        jxx("bub_cc_e", 4'h3);
        chk("bub_hold", 64'(last_cnd), 64'd0);
        step("xor_wins", 4'h6, 4'h3, 64'h77, 64'h77, 64'd0, 4'h1,
             3'd1, 3'd1, 3'd4, 1'b0, 1'b1);
        step("xor_ehlt", 4'h6, 4'h3, 64'h77, 64'h77, 64'd0, 4'h1,
             3'd2, 3'd1, 3'd1, 1'b0, 1'b1);
        jxx("estat_cc_e", 4'h3);
        chk("estat_hold", 64'(last_cnd), 64'd0);

        step("push", 4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        chk("push_valE", last_vale, 64'hF8);
        step("rst_mid", 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2,
             3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
        chk("rst_icode", 64'(vif.M_icode), 64'h1);
        chk("rst_dstE", 64'(vif.M_dstE), 64'hF);
        jxx("rst_cc_e", 4'h3);
        chk("rst_zf1", 64'(last_cnd), 64'd1);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  ic, fn;
            logic [63:0] a, b, c;
            logic [2:0]  es, ms, ws;
            ic = 4'($urandom_range(0, 12));
            fn = (ic == 4'h6) ? 4'($urandom_range(0, 3))
                              : 4'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 5) == 0) ? a : {$urandom, $urandom};
            c  = {$urandom, $urandom};
            es = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 4)) : 3'd1;
            ms = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
            ws = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 4)) : 3'd1;
            step("rand", ic, fn, a, b, c, 4'($urandom), es, ms, ws,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
